// File: rtl/bram_tree_arbiter.sv
// Round-robin arbiter/sequencer sharing one bram_tree priority queue between NUM_REQ requesters.
// Optional statistics counters are enabled by defining BRAM_TREE_ARB_STATS_EN.
module bram_tree_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 24,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [2*NUM_REQ-1:0]            i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic                            o_rsp_err,
  output logic                            o_busy,
  output logic                            o_q_wrt,
  output logic                            o_q_read,
  output logic [DATA_WIDTH-1:0]           o_q_data,
`ifdef BRAM_TREE_ARB_STATS_EN
  output logic [CNT_WIDTH-1:0]            o_op_cnt,
  output logic [CNT_WIDTH-1:0]            o_rej_cnt,
`endif
  input  logic                            i_q_full,
  input  logic                            i_q_empty,
  input  logic [DATA_WIDTH-1:0]           i_q_data
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [SetW-1:0]       cnt_q, cnt_d;
  logic                  legal_q, legal_d;
  logic                  wrt_q, wrt_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] qdata_q, qdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [IdxW-1:0]       cand;
  logic [1:0]            win_op;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_legal;
  logic [NUM_REQ-1:0]    grant_oh;
  logic                  grant;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_op   = i_req_op[32'(win_idx)*2 +: 2];
    win_data = i_req_data[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    grant_oh = '0;
    grant_oh[win_idx] = 1'b1;
  end

  // Legality uses the queue flags seen in the grant cycle.
  always_comb begin
    case (win_op)
      2'b01:        win_legal = !i_q_full;
      2'b10, 2'b11: win_legal = !i_q_empty;
      default:      win_legal = 1'b0;
    endcase
  end

  assign grant       = (state_q == StIdle) && win_found;
  assign o_req_ready = grant ? grant_oh : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    legal_d     = legal_q;
    busy_d      = busy_q;
    wrt_d       = 1'b0;
    read_d      = 1'b0;
    qdata_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StIssue;
          last_d      = win_idx;
          legal_d     = win_legal;
          busy_d      = 1'b1;
          rsp_valid_d = grant_oh;
          rsp_err_d   = !win_legal;
          if (win_legal) begin
            wrt_d   = win_op[0];
            read_d  = win_op[1];
            qdata_d = win_data;
            if (win_op[1]) begin
              rsp_data_d = i_q_data;
            end
          end
        end
      end
      StIssue: begin
        if (legal_q) begin
          state_d = StSettle;
          cnt_d   = SetW'(SETTLE_CYCLES);
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StSettle: begin
        if (cnt_q <= SetW'(1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - SetW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NUM_REQ - 1);
      cnt_q       <= '0;
      legal_q     <= 1'b0;
      busy_q      <= 1'b0;
      wrt_q       <= 1'b0;
      read_q      <= 1'b0;
      qdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      legal_q     <= legal_d;
      busy_q      <= busy_d;
      wrt_q       <= wrt_d;
      read_q      <= read_d;
      qdata_q     <= qdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_q_wrt     = wrt_q;
  assign o_q_read    = read_q;
  assign o_q_data    = qdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

`ifdef BRAM_TREE_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] op_cnt_q, rej_cnt_q;

  // Both counters saturate at all-ones.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_cnt_q  <= '0;
      rej_cnt_q <= '0;
    end else if (grant) begin
      if (win_legal && (op_cnt_q != '1)) begin
        op_cnt_q <= op_cnt_q + CNT_WIDTH'(1);
      end
      if (!win_legal && (rej_cnt_q != '1)) begin
        rej_cnt_q <= rej_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_op_cnt  = op_cnt_q;
  assign o_rej_cnt = rej_cnt_q;
`endif

endmodule
